// File: rtl/frame_sequencer_pkg.sv
// Shared types for the frame sequencer: state encoding and helpers.
// State values are visible on stateDbg, so the encodings are fixed.
package frame_sequencer_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    NF_WAIT = 3'd2,
    LV_WAIT = 3'd3,
    HOLD    = 3'd4
  } seq_state_t;

  function automatic logic isWaitState(input seq_state_t s);
    return (s == NF_WAIT) || (s == LV_WAIT) || (s == HOLD);
  endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags expiry
// combinationally once the count reaches TIMEOUT-1.
module frame_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/frame_sequencer.sv
// Frame scheduler: counts sample reads into frames and walks each frame through
// NoteFinder -> LinearVisualizer -> LED driver with one-cycle start pulses.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int SAMPLES_PER_FRAME = 64,
  parameter int SETTLE_CYCLES     = 4,
  parameter int TIMEOUT           = 65535,
  parameter int CNT_W             = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sampleRead,
  output logic                   nfStart,
  input  logic                   nfFinished,
  output logic                   lvStart,
  input  logic                   lvDone,
  output logic                   ledStart,
  input  logic                   ledDone,
  output logic                   busy,
  output logic [CNT_W-1:0]       framesDropped,
  output logic                   timeoutErr,
  output logic [SEQ_STATE_W-1:0] stateDbg
);

  localparam int SAMP_W = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t  state, stateNext;
  logic [SAMP_W-1:0] sampCnt;
  logic [SET_W-1:0]  settleCnt, settleNext;
  logic trigger, dropInc, ledBusy;
  logic nfStartNext, lvStartNext, ledStartNext;
  logic wdExpired, wdClear, wdEn;

  assign trigger = sampleRead && (sampCnt == SAMP_W'(SAMPLES_PER_FRAME - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sampCnt <= '0;
    end else if (sampleRead) begin
      sampCnt <= trigger ? '0 : sampCnt + SAMP_W'(1);
    end
  end

  always_comb begin
    stateNext    = state;
    settleNext   = settleCnt;
    nfStartNext  = 1'b0;
    lvStartNext  = 1'b0;
    ledStartNext = 1'b0;
    dropInc      = trigger && enable && (state != IDLE);
    case (state)
      IDLE: begin
        if (trigger && enable) begin
          if (SETTLE_CYCLES == 1) begin
            stateNext   = NF_WAIT;
            nfStartNext = 1'b1;
          end else begin
            stateNext  = SETTLE;
            settleNext = SET_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        // Leave one count early so the registered nfStart lands SETTLE_CYCLES after trigger.
        if (settleCnt <= SET_W'(1)) begin
          stateNext   = NF_WAIT;
          nfStartNext = 1'b1;
        end else begin
          settleNext = settleCnt - SET_W'(1);
        end
      end
      NF_WAIT: begin
        if (nfFinished) begin
          stateNext   = LV_WAIT;
          lvStartNext = 1'b1;
        end
      end
      LV_WAIT: begin
        if (lvDone) begin
          if (!ledBusy || ledDone) begin
            stateNext    = IDLE;
            ledStartNext = 1'b1;
          end else begin
            stateNext = HOLD;
          end
        end
      end
      HOLD: begin
        if (ledDone) begin
          stateNext    = IDLE;
          ledStartNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (wdExpired) begin
      stateNext    = IDLE;
      nfStartNext  = 1'b0;
      lvStartNext  = 1'b0;
      ledStartNext = 1'b0;
    end
  end

  assign wdEn    = isWaitState(state);
  assign wdClear = (stateNext != state);

  frame_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wdClear),
    .en      (wdEn),
    .expired (wdExpired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      settleCnt     <= '0;
      nfStart       <= 1'b0;
      lvStart       <= 1'b0;
      ledStart      <= 1'b0;
      ledBusy       <= 1'b0;
      framesDropped <= '0;
      timeoutErr    <= 1'b0;
    end else begin
      state     <= stateNext;
      settleCnt <= settleNext;
      nfStart   <= nfStartNext;
      lvStart   <= lvStartNext;
      ledStart  <= ledStartNext;
      // An abort drops any claim on the driver; otherwise a new start wins over ledDone.
      if (wdExpired) begin
        ledBusy <= 1'b0;
      end else if (ledStart) begin
        ledBusy <= 1'b1;
      end else if (ledDone) begin
        ledBusy <= 1'b0;
      end
      if (dropInc && (framesDropped != {CNT_W{1'b1}})) begin
        framesDropped <= framesDropped + CNT_W'(1);
      end
      if (wdExpired) begin
        timeoutErr <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign stateDbg = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: start pulses go through a scoreboard queue per DUT,
// status outputs are compared directly at scheduled cycles.
module tb_frame_sequencer;

  typedef struct {
    int kind;   // 0 nfStart, 1 lvStart, 2 ledStart
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sampleRead = 1'b0;
  logic nfFinished = 1'b0;
  logic lvDone = 1'b0;
  logic ledDone = 1'b0;
  logic selB = 1'b0;
  logic sampleReadA, sampleReadB;

  logic nfStartA, lvStartA, ledStartA, busyA, timeoutErrA;
  logic [1:0] framesDroppedA;
  logic [2:0] stateDbgA;
  logic nfStartB, lvStartB, ledStartB, busyB, timeoutErrB;
  logic [15:0] framesDroppedB;
  logic [2:0] stateDbgB;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t qA[$];
  exp_t qB[$];
  logic [2:0] pa, pb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sampleReadA = sampleRead & ~selB;
  assign sampleReadB = sampleRead & selB;

  frame_sequencer #(.SAMPLES_PER_FRAME(4), .SETTLE_CYCLES(4), .TIMEOUT(64), .CNT_W(2)) dutA (
    .clk(clk), .rst(rst), .enable(enable), .sampleRead(sampleReadA),
    .nfStart(nfStartA), .nfFinished(nfFinished), .lvStart(lvStartA), .lvDone(lvDone),
    .ledStart(ledStartA), .ledDone(ledDone), .busy(busyA), .framesDropped(framesDroppedA),
    .timeoutErr(timeoutErrA), .stateDbg(stateDbgA)
  );

  frame_sequencer #(.SAMPLES_PER_FRAME(4), .SETTLE_CYCLES(4), .TIMEOUT(16), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .enable(enable), .sampleRead(sampleReadB),
    .nfStart(nfStartB), .nfFinished(nfFinished), .lvStart(lvStartB), .lvDone(lvDone),
    .ledStart(ledStartB), .ledDone(ledDone), .busy(busyB), .framesDropped(framesDroppedB),
    .timeoutErr(timeoutErrB), .stateDbg(stateDbgB)
  );

  function automatic exp_t mk(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    return e;
  endfunction

  // Scoreboard monitor: every start pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    pa = {ledStartA, lvStartA, nfStartA};
    pb = {ledStartB, lvStartB, nfStartB};
    for (int k = 0; k < 3; k++) begin
      if (pa[k]) begin
        total++;
        if (qA.size() == 0) begin
          bad++;
          $display("FAIL dutA_pulse: start kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
          e = qA.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            bad++;
            $display("FAIL dutA_pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     k, cyc, e.kind, e.cyc);
          end
        end
      end
      if (pb[k]) begin
        total++;
        if (qB.size() == 0) begin
          bad++;
          $display("FAIL dutB_pulse: start kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
          e = qB.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            bad++;
            $display("FAIL dutB_pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Inputs are held for the current cycle, then cleared.
  task automatic drive(input logic sr, input logic nf, input logic lv, input logic ld);
    sampleRead = sr;
    nfFinished = nf;
    lvDone     = lv;
    ledDone    = ld;
    @(posedge clk);
    #1;
    sampleRead = 1'b0;
    nfFinished = 1'b0;
    lvDone     = 1'b0;
    ledDone    = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(output int t);
    t = 0;
    for (int i = 0; i < 4; i++) begin
      t = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int t;
    int c;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", stateDbgA, 0);
    check("reset_busy", busyA, 0);
    check("reset_drops", framesDroppedA, 0);
    check("reset_timeout", timeoutErrA, 0);
    rst = 1'b0;
    enable = 1'b1;

    // Basic frame
    sendFrame(t);
    qA.push_back(mk(0, t + 4));
    waitUntil(t + 4);
    check("basic_nfwait_state", stateDbgA, 2);
    check("basic_busy", busyA, 1);
    waitUntil(t + 10);
    qA.push_back(mk(1, t + 11));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(t + 15);
    qA.push_back(mk(2, t + 16));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(t + 16);
    check("basic_end_state", stateDbgA, 0);
    check("basic_end_busy", busyA, 0);

    // LED driver still busy: frame parks in HOLD
    sendFrame(t);
    qA.push_back(mk(0, t + 4));
    waitUntil(t + 6);
    qA.push_back(mk(1, t + 7));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(t + 9);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(t + 10);
    check("hold_state", stateDbgA, 4);
    waitUntil(t + 29);
    qA.push_back(mk(2, t + 30));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    waitUntil(t + 30);
    check("hold_end_state", stateDbgA, 0);
    check("hold_drops", framesDroppedA, 0);

    // lvDone and ledDone together while busy: straight to ledStart
    sendFrame(t);
    qA.push_back(mk(0, t + 4));
    waitUntil(t + 6);
    qA.push_back(mk(1, t + 7));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(t + 9);
    qA.push_back(mk(2, t + 10));
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    waitUntil(t + 10);
    check("simul_state", stateDbgA, 0);

    // Triggers with enable low in IDLE
    enable = 1'b0;
    sendFrame(t);
    sendFrame(t);
    waitUntil(t + 8);
    check("en0_state", stateDbgA, 0);
    check("en0_drops", framesDroppedA, 0);

    // Overrun drops, including an ignored trigger with enable low mid-frame
    enable = 1'b1;
    sendFrame(t);
    qA.push_back(mk(0, t + 4));
    waitUntil(t + 5);
    enable = 1'b0;
    sendFrame(c);
    check("drop_en0_mid", framesDroppedA, 0);
    check("drop_en0_noabort", stateDbgA, 2);
    enable = 1'b1;
    sendFrame(c);
    check("drop_first", framesDroppedA, 1);
    sendFrame(c);
    sendFrame(c);
    check("drop_three", framesDroppedA, 3);
    sendFrame(c);
    sendFrame(c);
    check("drop_saturate", framesDroppedA, 3);
    check("drop_still_nfwait", stateDbgA, 2);
    c = cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    qA.push_back(mk(1, c + 2));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(c + 4);
    qA.push_back(mk(2, c + 5));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(c + 5);
    check("drop_end_state", stateDbgA, 0);

    // Reset while in LV_WAIT
    sendFrame(t);
    qA.push_back(mk(0, t + 4));
    waitUntil(t + 6);
    qA.push_back(mk(1, t + 7));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(t + 8);
    check("rst_pre_state", stateDbgA, 3);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_state", stateDbgA, 0);
    check("rst_busy", busyA, 0);
    check("rst_drops", framesDroppedA, 0);
    check("rst_timeout", timeoutErrA, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(t + 13);
    check("rst_late_lvdone_state", stateDbgA, 0);

    // Watchdog on the short-timeout instance
    selB = 1'b1;
    sendFrame(t);
    qB.push_back(mk(0, t + 4));
    waitUntil(t + 19);
    check("wd_before_err", timeoutErrB, 0);
    check("wd_before_state", stateDbgB, 2);
    waitUntil(t + 20);
    check("wd_err", timeoutErrB, 1);
    check("wd_state", stateDbgB, 0);
    sendFrame(t);
    qB.push_back(mk(0, t + 4));
    waitUntil(t + 6);
    qB.push_back(mk(1, t + 7));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(t + 9);
    qB.push_back(mk(2, t + 10));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    waitUntil(t + 12);
    check("wd_sticky", timeoutErrB, 1);
    check("wd_good_state", stateDbgB, 0);
    check("wd_other_clean", timeoutErrA, 0);

    waitUntil(cyc + 4);
    check("pending_A", qA.size(), 0);
    check("pending_B", qB.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
